// File: rtl/vga_frame_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_frame_capture                                                          |
// | Captures one VGA frame, packs pixel pairs into 16-bit words, writes SRAM.  |
// | Optional test-pattern source: define VGA_CAP_TEST_PATTERN_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_frame_capture #(
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [7:0]        pixel_in,
`ifdef VGA_CAP_TEST_PATTERN_EN
  input  logic              test_pat,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       data_out,
  output logic              we_n,
  output logic              ce_n,
  output logic              lb_n,
  output logic              ub_n
);

  localparam int c_CNT_W  = 10;
  localparam int c_WCNT_W = ADDR_W + 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX     = '1;
  localparam logic [c_CNT_W-1:0]  c_H_LO        = c_CNT_W'(H_START);
  localparam logic [c_CNT_W-1:0]  c_H_HI        = c_CNT_W'(H_START + H_ACTIVE);
  localparam logic [c_CNT_W-1:0]  c_V_LO        = c_CNT_W'(V_START);
  localparam logic [c_CNT_W-1:0]  c_V_HI        = c_CNT_W'(V_START + V_ACTIVE);
  localparam logic [c_WCNT_W-1:0] c_FRAME_WORDS = c_WCNT_W'((H_ACTIVE / 2) * V_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_hs_d;
  logic                r_vs_d;
  logic [c_CNT_W-1:0]  r_h_cnt;
  logic [c_CNT_W-1:0]  r_v_cnt;
  logic [c_WCNT_W-1:0] r_word_cnt;
  logic [7:0]          r_low;
  logic                r_err;
  logic                r_we_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_data;

  logic                w_hs_fall;
  logic                w_vs_fall;
  logic                w_vs_start;
  logic [c_CNT_W-1:0]  w_h_cnt;
  logic [c_CNT_W-1:0]  w_v_cnt;
  logic                w_active;
  logic                w_x_odd;
  logic                w_wr;
  logic                w_arm_ok;
  logic [7:0]          w_byte;

  assign w_hs_fall  = r_hs_d & ~hsync_in;
  assign w_vs_fall  = r_vs_d & ~vsync_in;
  assign w_vs_start = (r_state == S_WAIT_VS) & w_vs_fall;

  // Counts valid for the current cycle: zero on the cycle the low sync is first seen.
  always_comb begin
    w_h_cnt = r_h_cnt;
    w_v_cnt = r_v_cnt;
    if (w_hs_fall) begin
      w_h_cnt = '0;
    end else if (r_h_cnt != c_CNT_MAX) begin
      w_h_cnt = r_h_cnt + c_CNT_W'(1);
    end
    if (w_vs_fall) begin
      w_v_cnt = '0;
    end else if (w_hs_fall && (r_v_cnt != c_CNT_MAX)) begin
      w_v_cnt = r_v_cnt + c_CNT_W'(1);
    end
  end

  assign w_active = (r_state == S_CAPTURE) && !w_vs_fall
                 && (w_h_cnt >= c_H_LO) && (w_h_cnt < c_H_HI)
                 && (w_v_cnt >= c_V_LO) && (w_v_cnt < c_V_HI);
  assign w_x_odd  = w_h_cnt[0] ^ c_H_LO[0];
  // Writes past a full frame are dropped so the address never wraps.
  assign w_wr     = w_active && w_x_odd && (r_word_cnt < c_FRAME_WORDS);

`ifdef VGA_CAP_TEST_PATTERN_EN
  logic [7:0] w_pat;
  assign w_pat  = (w_h_cnt[7:0] - c_H_LO[7:0]) ^ (w_v_cnt[7:0] - c_V_LO[7:0]);
  assign w_byte = test_pat ? w_pat : pixel_in;
`else
  assign w_byte = pixel_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_ok    = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    ce_n        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (arm) begin
          w_state_nxt = S_WAIT_VS;
          w_arm_ok    = 1'b1;
        end
      end
      S_WAIT_VS: begin
        ce_n = 1'b0;
        if (w_vs_fall) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        ce_n = 1'b0;
        if (w_vs_fall) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_d     <= 1'b1;
      r_vs_d     <= 1'b1;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_word_cnt <= '0;
      r_low      <= '0;
      r_err      <= 1'b0;
      r_we_n     <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_hs_d  <= hsync_in;
      r_vs_d  <= vsync_in;
      r_h_cnt <= w_h_cnt;
      r_v_cnt <= w_v_cnt;
      if (w_arm_ok) begin
        r_err <= 1'b0;
      end else if ((r_state == S_DONE) && (r_word_cnt != c_FRAME_WORDS)) begin
        r_err <= 1'b1;
      end
      if (w_vs_start) begin
        r_word_cnt <= '0;
      end else if (w_wr) begin
        r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
      end
      if (w_active && !w_x_odd) r_low <= w_byte;
      r_we_n <= ~w_wr;
      if (w_wr) begin
        r_addr <= r_word_cnt[ADDR_W-1:0];
        r_data <= {w_byte, r_low};
      end
    end
  end

  assign err      = r_err;
  assign addr     = r_addr;
  assign data_out = r_data;
  assign we_n     = r_we_n;
  assign lb_n     = r_we_n;
  assign ub_n     = r_we_n;

endmodule
`default_nettype wire
